vga_port_arb: RTL and testbench

Two-requester arbiter for the VGA text controller's register port (cmd / cursor address / data out / data in / cs_h / rl_wh / ready_h). Requester 0 is the SPI command front-end; requester 1 is the local boot-banner / test-pattern writer. Each requester owns a one-deep request slot. The arbiter serialises slot contents onto the single VGA port and returns read data to the requester that issued the read.

---
 rtl/vga_port_pkg.sv | 22 ++
 rtl/vga_arb_slot.sv | 58 +++++
 rtl/vga_port_arb.sv | 141 ++++++++++++++
 tb/tb_vga_port_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_port_pkg.sv
// Shared definitions for the VGA register-port arbiter: command codes,
// FSM state encoding and default widths.
package vga_port_pkg;

    localparam int ADR_W_DEF = 11;
    localparam int DAT_W_DEF = 8;

    localparam logic [7:0] CMD_STATUS  = 8'h00;
    localparam logic [7:0] CMD_DATA    = 8'h01;
    localparam logic [7:0] CMD_CUR_ADR = 8'h02;
    localparam logic [7:0] CMD_CONTROL = 8'h04;
    localparam logic [7:0] CMD_COLOR   = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_WAIT_RDY,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/vga_arb_slot.sv
// One-deep request buffer for a single requester: captures a strobed request,
// flags overflow on strobes while full, and empties when the arbiter releases it.
module vga_arb_slot
    import vga_port_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cs_h,
    input  logic             i_rl_wh,
    input  logic [DAT_W-1:0] i_cmd,
    input  logic [ADR_W-1:0] i_cur_adr,
    input  logic [DAT_W-1:0] i_wdata,
    input  logic             i_release,
    output logic             o_full,
    output logic             o_ready_h,
    output logic             o_ovf,
    output logic             o_rl_wh,
    output logic [DAT_W-1:0] o_cmd,
    output logic [ADR_W-1:0] o_cur_adr,
    output logic [DAT_W-1:0] o_wdata
);

    logic accept;
    logic drop;
    logic full_nxt;

    // A release in the same cycle frees the slot, so a coincident strobe refills it.
    assign accept   = i_cs_h && (!o_full || i_release);
    assign drop     = i_cs_h && o_full && !i_release;
    assign full_nxt = accept || (o_full && !i_release);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_full    <= 1'b0;
            o_ready_h <= 1'b1;
            o_ovf     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            o_full    <= full_nxt;
            o_ready_h <= !full_nxt;
            o_ovf     <= o_ovf || drop;
        end
    end

    // NOTE: payload registers carry no reset; they are only read while o_full is set.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            o_rl_wh   <= i_rl_wh;
            o_cmd     <= i_cmd;
            o_cur_adr <= i_cur_adr;
            o_wdata   <= i_wdata;
        end
    end

endmodule

// File: rtl/vga_port_arb.sv
// Two-requester arbiter serialising request slots onto the VGA register port.
// Define VGA_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module vga_port_arb
    import vga_port_pkg::*;
#(
    parameter int ADR_W = ADR_W_DEF,
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_r0_cs_h,
    input  logic             i_r0_rl_wh,
    input  logic [DAT_W-1:0] i_r0_cmd,
    input  logic [ADR_W-1:0] i_r0_cur_adr,
    input  logic [DAT_W-1:0] i_r0_wdata,
    output logic             o_r0_ready_h,
    output logic [DAT_W-1:0] o_r0_rdata,
    output logic             o_r0_rvalid,
    output logic             o_r0_ovf,
    input  logic             i_r1_cs_h,
    input  logic             i_r1_rl_wh,
    input  logic [DAT_W-1:0] i_r1_cmd,
    input  logic [ADR_W-1:0] i_r1_cur_adr,
    input  logic [DAT_W-1:0] i_r1_wdata,
    output logic             o_r1_ready_h,
    output logic [DAT_W-1:0] o_r1_rdata,
    output logic             o_r1_rvalid,
    output logic             o_r1_ovf,
    output logic [DAT_W-1:0] o_vga_cmd,
    output logic [ADR_W-1:0] o_vga_cur_adr,
    output logic [DAT_W-1:0] o_vga_port,
    output logic             o_vga_cs_h,
    output logic             o_vga_rl_wh,
    input  logic [DAT_W-1:0] i_vga_port,
    input  logic             i_vga_ready_h
);

    arb_state_t state, state_nxt;

    wire              full0, full1;
    wire              slot_rl_wh [2];
    wire  [DAT_W-1:0] slot_cmd   [2];
    wire  [ADR_W-1:0] slot_adr   [2];
    wire  [DAT_W-1:0] slot_wdata [2];
    logic [1:0]       rel;
    logic             load;
    logic             pick;
    logic             winner;
    logic             prio;

    vga_arb_slot #(.ADR_W(ADR_W), .DAT_W(DAT_W)) u_slot0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_cs_h(i_r0_cs_h), .i_rl_wh(i_r0_rl_wh),
        .i_cmd(i_r0_cmd), .i_cur_adr(i_r0_cur_adr), .i_wdata(i_r0_wdata),
        .i_release(rel[0]), .o_full(full0), .o_ready_h(o_r0_ready_h), .o_ovf(o_r0_ovf),
        .o_rl_wh(slot_rl_wh[0]), .o_cmd(slot_cmd[0]), .o_cur_adr(slot_adr[0]),
        .o_wdata(slot_wdata[0])
    );

    vga_arb_slot #(.ADR_W(ADR_W), .DAT_W(DAT_W)) u_slot1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_cs_h(i_r1_cs_h), .i_rl_wh(i_r1_rl_wh),
        .i_cmd(i_r1_cmd), .i_cur_adr(i_r1_cur_adr), .i_wdata(i_r1_wdata),
        .i_release(rel[1]), .o_full(full1), .o_ready_h(o_r1_ready_h), .o_ovf(o_r1_ovf),
        .o_rl_wh(slot_rl_wh[1]), .o_cmd(slot_cmd[1]), .o_cur_adr(slot_adr[1]),
        .o_wdata(slot_wdata[1])
    );

`ifdef VGA_ARB_FIXED_PRIO_EN
    assign pick = !full0;
`else
    // prio names the requester that wins a tie; with one slot full that slot wins.
    assign pick = (full0 && full1) ? prio : full1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_nxt = state;
        load      = 1'b0;
        rel       = 2'b00;
        unique case (state)
            ST_IDLE: begin
                if ((full0 || full1) && i_vga_ready_h) begin
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE:    state_nxt = ST_SETTLE;
            ST_SETTLE:   state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: if (i_vga_ready_h) state_nxt = ST_DONE;
            ST_DONE: begin
                rel[winner] = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vga_cmd     <= '0;
            o_vga_cur_adr <= '0;
            o_vga_port    <= '0;
            o_vga_rl_wh   <= 1'b0;
            o_vga_cs_h    <= 1'b0;
            winner        <= 1'b0;
            prio          <= 1'b0;
            o_r0_rdata    <= '0;
            o_r1_rdata    <= '0;
            o_r0_rvalid   <= 1'b0;
            o_r1_rvalid   <= 1'b0;
        end else begin
            o_vga_cs_h  <= load;
            o_r0_rvalid <= 1'b0;
            o_r1_rvalid <= 1'b0;
            if (load) begin
                winner        <= pick;
                o_vga_cmd     <= slot_cmd[pick];
                o_vga_cur_adr <= slot_adr[pick];
                o_vga_port    <= slot_wdata[pick];
                o_vga_rl_wh   <= slot_rl_wh[pick];
            end
            if (state == ST_DONE) begin
                prio <= !winner;
                if (!o_vga_rl_wh) begin
                    if (winner) begin
                        o_r1_rdata  <= i_vga_port;
                        o_r1_rvalid <= 1'b1;
                    end else begin
                        o_r0_rdata  <= i_vga_port;
                        o_r0_rvalid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_port_arb.sv
// Self-checking bench for vga_port_arb: timing, reads, arbitration order,
// overflow, mid-transaction reset, address hold and randomized single transactions.
module tb_vga_port_arb;
    import vga_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_cs, r0_rw, r1_cs, r1_rw;
    logic [7:0]  r0_cmd, r0_wd, r1_cmd, r1_wd;
    logic [10:0] r0_adr, r1_adr;
    logic [7:0]  vga_din;
    logic        vga_ready;
    wire  [1:0]  ready_h, rvalid, ovf;
    wire  [7:0]  rdata0, rdata1;
    wire  [7:0]  vga_cmd, vga_port;
    wire  [10:0] vga_adr;
    wire         vga_cs, vga_rw;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_rdata [2];

    always #5 clk = ~clk;

    vga_port_arb dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_cs_h(r0_cs), .i_r0_rl_wh(r0_rw), .i_r0_cmd(r0_cmd), .i_r0_cur_adr(r0_adr),
        .i_r0_wdata(r0_wd), .o_r0_ready_h(ready_h[0]), .o_r0_rdata(rdata0),
        .o_r0_rvalid(rvalid[0]), .o_r0_ovf(ovf[0]),
        .i_r1_cs_h(r1_cs), .i_r1_rl_wh(r1_rw), .i_r1_cmd(r1_cmd), .i_r1_cur_adr(r1_adr),
        .i_r1_wdata(r1_wd), .o_r1_ready_h(ready_h[1]), .o_r1_rdata(rdata1),
        .o_r1_rvalid(rvalid[1]), .o_r1_ovf(ovf[1]),
        .o_vga_cmd(vga_cmd), .o_vga_cur_adr(vga_adr), .o_vga_port(vga_port),
        .o_vga_cs_h(vga_cs), .o_vga_rl_wh(vga_rw),
        .i_vga_port(vga_din), .i_vga_ready_h(vga_ready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int req, input logic rw, input logic [7:0] cmd,
                         input logic [10:0] adr, input logic [7:0] wd);
        if (req == 0) begin
            r0_cs = 1'b1; r0_rw = rw; r0_cmd = cmd; r0_adr = adr; r0_wd = wd;
        end else begin
            r1_cs = 1'b1; r1_rw = rw; r1_cmd = cmd; r1_adr = adr; r1_wd = wd;
        end
    endtask

    task automatic release_strobes();
        r0_cs = 1'b0;
        r1_cs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        release_strobes();
        vga_ready = 1'b1;
        vga_din = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
    endtask

    task automatic wait_cs(input string name, output bit ok);
        int n = 0;
        while (!vga_cs && n < 20) begin
            tick();
            n++;
        end
        ok = vga_cs;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no o_vga_cs_h within 20 cycles (got 0, need 1)", name);
        end
    endtask

    // One complete transaction with a responding VGA model; dly = cycles of ready low from cs.
    task automatic do_xact(input string name, input int req, input logic rw,
                           input logic [7:0] cmd, input logic [10:0] adr,
                           input logic [7:0] wd, input int dly, input logic [7:0] rd);
        bit ok;
        int n;
        vga_ready = 1'b1;
        drive(req, rw, cmd, adr, wd);
        tick();
        release_strobes();
        wait_cs(name, ok);
        if (!ok) return;
        checks++;
        if ({vga_rw, vga_cmd, vga_adr} !== {rw, cmd, adr}) begin
            errors++;
            $display("FAIL %s fields: got rw=%b cmd=%h adr=%h, need rw=%b cmd=%h adr=%h",
                     name, vga_rw, vga_cmd, vga_adr, rw, cmd, adr);
        end
        if (rw) begin
            checks++;
            if (vga_port !== wd) begin
                errors++;
                $display("FAIL %s wdata: got %h need %h", name, vga_port, wd);
            end
        end
        if (dly > 0) begin
            vga_ready = 1'b0;
            repeat (dly) tick();
        end
        vga_ready = 1'b1;
        vga_din = rd;
        n = 0;
        do begin
            tick();
            n++;
            checks++;
            if (vga_adr !== adr || vga_cmd !== cmd || vga_cs !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: got adr=%h cmd=%h cs=%b, need adr=%h cmd=%h cs=0",
                         name, vga_adr, vga_cmd, vga_cs, adr, cmd);
            end
        end while (!ready_h[req] && n < 30);
        checks++;
        if (!ready_h[req]) begin
            errors++;
            $display("FAIL %s done: ready_h stuck at 0, need 1", name);
            return;
        end
        if (!rw) exp_rdata[req] = rd;
        checks++;
        if (rvalid[req] !== !rw || rvalid[1-req] !== 1'b0) begin
            errors++;
            $display("FAIL %s rvalid: got %b need r%0d=%b other=0", name, rvalid, req, !rw);
        end
        checks++;
        if (rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1]) begin
            errors++;
            $display("FAIL %s rdata: got %h/%h need %h/%h", name, rdata0, rdata1,
                     exp_rdata[0], exp_rdata[1]);
        end
        tick();
        checks++;
        if (rvalid !== 2'b00) begin
            errors++;
            $display("FAIL %s rvalid_pulse: got %b need 00", name, rvalid);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({vga_cmd, vga_adr, vga_port, vga_cs, vga_rw} !== '0 || rdata0 !== 8'h00 ||
            rdata1 !== 8'h00 || rvalid !== 2'b00 || ovf !== 2'b00 || ready_h !== 2'b11) begin
            errors++;
            $display("FAIL %s: got cmd=%h adr=%h port=%h cs=%b rw=%b rd=%h/%h rv=%b ovf=%b rdy=%b, need all 0 and rdy=11",
                     name, vga_cmd, vga_adr, vga_port, vga_cs, vga_rw, rdata0, rdata1, rvalid, ovf, ready_h);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_outputs("reset_state");
    endtask

    task automatic test_write_timing();
        logic [10:0] adr = 11'($urandom);
        do_reset();
        drive(0, 1'b1, CMD_DATA, adr, 8'h41);
        tick();
        release_strobes();
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (vga_cs !== (k == 2) || ready_h[0] !== (k >= 6) || rvalid !== 2'b00) begin
                errors++;
                $display("FAIL wr_timing t+%0d: got cs=%b rdy0=%b rv=%b, need cs=%b rdy0=%b rv=00",
                         k, vga_cs, ready_h[0], rvalid, k == 2, k >= 6);
            end
            if (k == 2) begin
                checks++;
                if (vga_port !== 8'h41 || vga_rw !== 1'b1 || vga_cmd !== CMD_DATA || vga_adr !== adr) begin
                    errors++;
                    $display("FAIL wr_fields: got port=%h rw=%b cmd=%h adr=%h, need 41 1 01 %h",
                             vga_port, vga_rw, vga_cmd, vga_adr, adr);
                end
            end
            tick();
        end
    endtask

    task automatic test_read_r1();
        do_xact("rd_r1", 1, 1'b0, CMD_STATUS, 11'($urandom), 8'($urandom), 5, 8'h5A);
    endtask

    task automatic test_back_to_back();
        int  sent [2];
        bit  pend [2];
        int  served [2];
        int  last;
        int  exp_w [6];
        int  w;
        bit  ok;
        logic [10:0] adr = 11'($urandom);
        // Expected grant order from the queue-level arbitration rule.
        sent = '{1, 1}; pend = '{1'b1, 1'b1}; last = 1;
        for (int g = 0; g < 6; g++) begin
            if (pend[0] && pend[1]) begin
`ifdef VGA_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = (last == 0) ? 1 : 0;
`endif
            end else begin
                w = pend[0] ? 0 : 1;
            end
            exp_w[g] = w;
            pend[w] = 1'b0;
            if (sent[w] < 3) begin
                pend[w] = 1'b1;
                sent[w]++;
            end
            last = w;
        end
        do_reset();
        served = '{0, 0};
        sent = '{1, 1};
        drive(0, 1'b1, CMD_DATA, adr, 8'h00);
        drive(1, 1'b1, CMD_DATA, adr, 8'h10);
        tick();
        release_strobes();
        for (int g = 0; g < 6; g++) begin
            wait_cs("b2b_cs", ok);
            if (!ok) return;
            w = int'(vga_port[4]);
            checks++;
            if (w !== exp_w[g] || vga_port[3:0] !== 4'(served[w])) begin
                errors++;
                $display("FAIL b2b grant %0d: got port=%h, need requester %0d index %0d",
                         g, vga_port, exp_w[g], served[exp_w[g]]);
            end
            served[w]++;
            repeat (3) tick();
            if (sent[w] < 3) begin
                drive(w, 1'b1, CMD_DATA, adr, 8'(w * 16 + sent[w]));
                sent[w]++;
            end
            tick();
            release_strobes();
        end
        repeat (6) tick();
        checks++;
        if (ovf !== 2'b00 || ready_h !== 2'b11) begin
            errors++;
            $display("FAIL b2b end: got ovf=%b rdy=%b, need ovf=00 rdy=11", ovf, ready_h);
        end
    endtask

    task automatic test_ovf();
        int cs_count = 0;
        do_reset();
        drive(0, 1'b1, CMD_DATA, 11'h005, 8'hA1);
        tick();
        drive(0, 1'b1, CMD_DATA, 11'h006, 8'hB2);
        tick();
        release_strobes();
        for (int k = 2; k < 16; k++) begin
            if (vga_cs) begin
                cs_count++;
                checks++;
                if (vga_port !== 8'hA1 || vga_adr !== 11'h005) begin
                    errors++;
                    $display("FAIL ovf payload: got port=%h adr=%h, need A1 005", vga_port, vga_adr);
                end
            end
            checks++;
            if (ovf !== 2'b01) begin
                errors++;
                $display("FAIL ovf flag t+%0d: got %b need 01", k, ovf);
            end
            tick();
        end
        checks++;
        if (cs_count != 1) begin
            errors++;
            $display("FAIL ovf cs_count: got %0d need 1", cs_count);
        end
    endtask

    task automatic test_reset_mid();
        int cs_count = 0;
        do_reset();
        exp_rdata[0] = 8'h00;
        drive(0, 1'b0, CMD_COLOR, 11'h123, 8'h77);
        tick();
        drive(0, 1'b1, CMD_DATA, 11'h124, 8'h78);
        drive(1, 1'b1, CMD_CONTROL, 11'h321, 8'h99);
        tick();
        release_strobes();
        vga_ready = 1'b0;
        tick();
        checks++;
        if (ovf !== 2'b01 || vga_rw !== 1'b0 || vga_adr !== 11'h123) begin
            errors++;
            $display("FAIL rst_mid pre: got ovf=%b rw=%b adr=%h, need 01 0 123", ovf, vga_rw, vga_adr);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vga_ready = 1'b1;
        check_idle_outputs("rst_mid_state");
        for (int k = 0; k < 10; k++) begin
            if (vga_cs || rvalid !== 2'b00) cs_count++;
            tick();
        end
        checks++;
        if (cs_count != 0) begin
            errors++;
            $display("FAIL rst_mid abandon: got %0d cs/rvalid cycles, need 0", cs_count);
        end
        do_xact("rst_mid_fresh", 0, 1'b0, CMD_STATUS, 11'h042, 8'h00, 2, 8'hC3);
    endtask

    task automatic test_adr_hold();
        do_reset();
        do_xact("adr_7ff", 0, 1'b1, CMD_CUR_ADR, 11'h7FF, 8'h00, 0, 8'h00);
        repeat (4) tick();
        checks++;
        if (vga_adr !== 11'h7FF || vga_cmd !== CMD_CUR_ADR) begin
            errors++;
            $display("FAIL adr_hold1: got adr=%h cmd=%h, need 7ff 02", vga_adr, vga_cmd);
        end
        do_xact("adr_010", 0, 1'b1, CMD_DATA, 11'h010, 8'h55, 1, 8'h00);
        repeat (4) tick();
        checks++;
        if (vga_adr !== 11'h010 || vga_port !== 8'h55) begin
            errors++;
            $display("FAIL adr_hold2: got adr=%h port=%h, need 010 55", vga_adr, vga_port);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_xact("random", int'($urandom_range(1, 0)), 1'($urandom), 8'($urandom) & 8'h7F,
                    11'($urandom), 8'($urandom), int'($urandom_range(4, 0)), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        r0_cs = 1'b0; r0_rw = 1'b0; r0_cmd = '0; r0_adr = '0; r0_wd = '0;
        r1_cs = 1'b0; r1_rw = 1'b0; r1_cmd = '0; r1_adr = '0; r1_wd = '0;
        vga_ready = 1'b1;
        vga_din = '0;
        test_reset();
        test_write_timing();
        test_read_r1();
        test_back_to_back();
        test_ovf();
        test_reset_mid();
        test_adr_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
